// File: rtl/butterfly_mac.sv
// butterfly_mac: time-multiplexed complex MAC pair building A + B*W over three select steps.
// Accumulators wrap modulo 2^(2*data_width) and feed O_real/O_imag directly.
module butterfly_mac #(
    parameter int data_width = 4
) (
    input  logic                           clk_MAC,
    input  logic                           aclr,
    input  logic signed [data_width-1:0]   A_real,
    input  logic signed [data_width-1:0]   A_imag,
    input  logic signed [data_width-1:0]   B_real,
    input  logic signed [data_width-1:0]   B_imag,
    input  logic signed [data_width-1:0]   W_real,
    input  logic signed [data_width-1:0]   W_imag,
    input  logic                           sload,
    input  logic [1:0]                     select,
    output logic signed [2*data_width-1:0] O_real,
    output logic signed [2*data_width-1:0] O_imag
);
    localparam int W2 = 2 * data_width;
    logic signed [W2-1:0] ar, ai, br, bi, wr, wi, add_r, add_i;
    assign ar = W2'(A_real);
    assign ai = W2'(A_imag);
    assign br = W2'(B_real);
    assign bi = W2'(B_imag);
    assign wr = W2'(W_real);
    assign wi = W2'(W_imag);
    // select 11 contributes zero: holds with sload=0, clears with sload=1
    always_comb begin
        add_r = select == 2'b00 ? br * wr : select == 2'b01 ? -(bi * wi) : select == 2'b10 ? ar : '0;
        add_i = select == 2'b00 ? br * wi : select == 2'b01 ? bi * wr : select == 2'b10 ? ai : '0;
    end
    always_ff @(posedge clk_MAC or negedge aclr) begin
        if (!aclr) begin
            O_real <= '0;
            O_imag <= '0;
        end else begin
            O_real <= sload ? add_r : O_real + add_r;
            O_imag <= sload ? add_i : O_imag + add_i;
        end
    end
endmodule

// File: tb/tb_butterfly_mac.sv
// tb_butterfly_mac: directed and randomized checks of butterfly_mac against an integer model.
module tb_butterfly_mac;
    logic clk_MAC = 0;
    logic aclr = 0;
    logic [3:0] A_real, A_imag, B_real, B_imag, W_real, W_imag;
    logic sload;
    logic [1:0] select;
    logic [7:0] O_real, O_imag;
    int errors = 0;
    int checks = 0;
    int mr = 0;
    int mi = 0;

    butterfly_mac #(.data_width(4)) dut (
        .clk_MAC(clk_MAC), .aclr(aclr),
        .A_real(A_real), .A_imag(A_imag),
        .B_real(B_real), .B_imag(B_imag),
        .W_real(W_real), .W_imag(W_imag),
        .sload(sload), .select(select),
        .O_real(O_real), .O_imag(O_imag)
    );

    always #5 clk_MAC = ~clk_MAC;

    function automatic int sx(input logic [3:0] v);
        return $signed(v);
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    task automatic set_all(input logic [3:0] ar, ai, br, bi, wr, wi);
        A_real = ar; A_imag = ai; B_real = br; B_imag = bi; W_real = wr; W_imag = wi;
    endtask

    // complex A + B*W built term by term from the select table, wrapped to 8 bits
    task automatic step(input string tag, input logic sl, input logic [1:0] sel);
        int xr, xi;
        sload = sl;
        select = sel;
        @(posedge clk_MAC);
        #1;
        case (sel)
            2'b00: begin xr = sx(B_real) * sx(W_real); xi = sx(B_real) * sx(W_imag); end
            2'b01: begin xr = -(sx(B_imag) * sx(W_imag)); xi = sx(B_imag) * sx(W_real); end
            2'b10: begin xr = sx(A_real); xi = sx(A_imag); end
            default: begin xr = 0; xi = 0; end
        endcase
        mr = (sl ? xr : mr + xr) & 255;
        mi = (sl ? xi : mi + xi) & 255;
        check({tag, "_re"}, O_real, mr[7:0]);
        check({tag, "_im"}, O_imag, mi[7:0]);
    endtask

    task automatic pulse_reset(input string tag);
        #2 aclr = 0;
        #1;
        mr = 0;
        mi = 0;
        check({tag, "_re"}, O_real, 8'd0);
        check({tag, "_im"}, O_imag, 8'd0);
        #1 aclr = 1;
    endtask

    initial begin
        sload = 0;
        select = 2'b00;
        set_all(4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5);
        #3;
        check("rst_async_re", O_real, 8'd0);
        check("rst_async_im", O_imag, 8'd0);
        repeat (2) @(posedge clk_MAC);
        #1;
        check("rst_hold_re", O_real, 8'd0);
        check("rst_hold_im", O_imag, 8'd0);
        aclr = 1;
        step("t2_s00", 0, 2'b00);
        check("t2_s00_lit", O_real, 8'd25);
        step("t2_s01", 0, 2'b01);
        check("t2_s01_lit", O_imag, 8'd50);
        step("t2_s10", 0, 2'b10);
        check("t2_s10_lit_re", O_real, 8'd5);
        check("t2_s10_lit_im", O_imag, 8'd55);
        step("t3_s00", 1, 2'b00);
        check("t3_s00_lit", O_real, 8'd25);
        step("t3_s01", 0, 2'b01);
        step("t3_s10", 0, 2'b10);
        check("t3_s10_lit", O_imag, 8'd55);
        set_all(4'd0, 4'd0, 4'hF, 4'd0, 4'd7, 4'd0);
        step("t4_sign", 1, 2'b00);
        check("t4_sign_lit", O_real, 8'hF9);
        set_all(4'd7, 4'd0, 4'h8, 4'd0, 4'h8, 4'd0);
        step("t5_sq", 1, 2'b00);
        check("t5_sq_lit", O_real, 8'd64);
        for (int i = 0; i < 9; i++) step("t5_acc", 0, 2'b10);
        check("t5_max", O_real, 8'd127);
        step("t5_wrap", 0, 2'b10);
        check("t5_wrap_lit", O_real, 8'h86);
        for (int i = 0; i < 3; i++) step("t6_hold", 0, 2'b11);
        check("t6_hold_lit", O_real, 8'h86);
        step("t6_clear", 1, 2'b11);
        check("t6_clear_lit", O_real, 8'd0);
        set_all(4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5);
        step("t6_pre", 1, 2'b00);
        pulse_reset("t6_midrst");
        step("t6_after", 0, 2'b01);
        check("t6_after_lit", O_imag, 8'd25);
        for (int i = 0; i < 300; i++) begin
            set_all($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
            if ($urandom_range(0, 39) == 0) pulse_reset("rnd_rst");
            step("rnd", ($urandom_range(0, 3) == 0), 2'($urandom));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
